// File: rtl/bit_msg_pkg.sv
// ---------------------------------------------------------------------------
// bit_msg_pkg
//   Shared constants and types for the bit-reversal message source stage:
//   the data/address widths, the 16-byte message ROM ("FPGA BitReversal"),
//   and a lookup helper.
// ---------------------------------------------------------------------------
package bit_msg_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef logic [DATA_W-1:0] byte_t;
    typedef logic [ADDR_W-1:0] addr_t;

    // "FPGA BitReversal", index 0 first
    localparam byte_t MSG_ROM [DEPTH] = '{
        8'h46, 8'h50, 8'h47, 8'h41, 8'h20, 8'h42, 8'h69, 8'h74,
        8'h52, 8'h65, 8'h76, 8'h65, 8'h72, 8'h73, 8'h61, 8'h6C
    };

    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

    function automatic byte_t msg_byte(input addr_t idx);
        return MSG_ROM[idx];
    endfunction

endpackage

// File: rtl/msg_ram16x8.sv
// ---------------------------------------------------------------------------
// msg_ram16x8
//   16 x 8 message RAM with asynchronous clear and a registered, write-first
//   read port. On a write cycle the written byte is echoed on rdata_o one
//   edge later; otherwise the addressed word is read back.
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   async active-low clear of all words and outputs
//   wr_en_i   in   write strobe for addr_i/wdata_i
//   addr_i    in   word address
//   wdata_i   in   write data
//   rdata_o   out  registered read data (write-first)
//   rvalid_o  out  rdata_o holds the byte written on the previous edge
// ---------------------------------------------------------------------------
module msg_ram16x8
    import bit_msg_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o
);

    byte_t mem_q [DEPTH];
    byte_t rdata_q;
    byte_t rdata_d;
    logic  rvalid_q;

    always_comb begin
        rdata_d = mem_q[addr_i];
        if (wr_en_i) begin
            rdata_d = wdata_i;
        end
    end

    // Storage is plain flops so the whole array can clear asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                mem_q[addr_i] <= wdata_i;
            end
            rdata_q  <= rdata_d;
            rvalid_q <= wr_en_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;

endmodule

// File: rtl/bit_message_store.sv
// ---------------------------------------------------------------------------
// bit_message_store
//   Source stage of the bit-reversal datapath. Replays the 16-byte message
//   one byte per clock, writes each byte into the message RAM and forwards
//   the echoed byte to the bit-reversal stage.
// Ports
//   clk         in   clock, rising edge
//   reset       in   async active-low; deassertion synchronized internally
//   addr        out  RAM address of the byte on bit_out
//   bit_out     out  message byte being written this cycle
//   wr_valid    out  addr/bit_out are a valid write
//   byte_out    out  registered RAM read data (write-first)
//   byte_valid  out  byte_out holds a valid message byte
//   pass_done   out  sticky: every RAM location written at least once
// ---------------------------------------------------------------------------
module bit_message_store
    import bit_msg_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] bit_out,
    output logic              wr_valid,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              pass_done
);

    // Assert asynchronously, release two edges after reset rises.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    addr_t idx_q,       idx_d;
    addr_t addr_q,      addr_d;
    byte_t bit_out_q,   bit_out_d;
    logic  wr_valid_q,  wr_valid_d;
    logic  pass_done_q, pass_done_d;

    always_comb begin
        // idx is ADDR_W wide, so 15 + 1 wraps to 0 with no gap
        idx_d       = idx_q + addr_t'(1);
        addr_d      = idx_q;
        bit_out_d   = msg_byte(idx_q);
        wr_valid_d  = 1'b1;
        // Set on the same edge the RAM commits the write to the last address.
        pass_done_d = pass_done_q | (wr_valid_q && (addr_q == LAST_ADDR));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q       <= '0;
            addr_q      <= '0;
            bit_out_q   <= '0;
            wr_valid_q  <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            addr_q      <= addr_d;
            bit_out_q   <= bit_out_d;
            wr_valid_q  <= wr_valid_d;
            pass_done_q <= pass_done_d;
        end
    end

    msg_ram16x8 u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_valid_q),
        .addr_i   (addr_q),
        .wdata_i  (bit_out_q),
        .rdata_o  (byte_out),
        .rvalid_o (byte_valid)
    );

    assign addr      = addr_q;
    assign bit_out   = bit_out_q;
    assign wr_valid  = wr_valid_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_bit_message_store.sv
module tb_bit_message_store;

    logic       clk;
    logic       reset;
    logic [3:0] addr;
    logic [7:0] bit_out;
    logic       wr_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       pass_done;

    bit_message_store dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .bit_out    (bit_out),
        .wr_valid   (wr_valid),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .pass_done  (pass_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         a;
        logic [7:0] d;
    } sb_t;

    sb_t        sb [$];
    logic [7:0] rom [16];
    int         exp_idx;
    logic       exp_pass;
    int         n_checks;
    int         n_pass;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({addr, bit_out, wr_valid, byte_out, byte_valid, pass_done} !== 23'd0)
            $display("FAIL reset_outputs: got addr=%h bit_out=%h wr_valid=%b byte_out=%h byte_valid=%b pass_done=%b, want all 0",
                     addr, bit_out, wr_valid, byte_out, byte_valid, pass_done);
        else n_pass++;
    endtask

    // Waits (bounded) for the first write after release and checks it.
    task automatic wait_first_write(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (wr_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL %s_timeout: wr_valid=%b, want 1 within 6 edges", tag, wr_valid);
        else n_pass++;
        n_checks++;
        if (addr !== 4'd0 || bit_out !== rom[0])
            $display("FAIL %s_first: addr=%h bit_out=%h, want addr=0 bit_out=%h", tag, addr, bit_out, rom[0]);
        else n_pass++;
        n_checks++;
        if (byte_valid !== 1'b0 || pass_done !== 1'b0)
            $display("FAIL %s_first_flags: byte_valid=%b pass_done=%b, want 0 0", tag, byte_valid, pass_done);
        else n_pass++;
        sb.push_back('{0, rom[0]});
        exp_idx = 1;
    endtask

    task automatic run_stream(input int n);
        sb_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (byte_valid !== 1'b1 || byte_out !== e.d)
                    $display("FAIL byte_out[a=%0d]: byte_valid=%b byte_out=%h, want 1 %h", e.a, byte_valid, byte_out, e.d);
                else n_pass++;
                if (e.a == 15) exp_pass = 1'b1;
            end
            n_checks++;
            if (pass_done !== exp_pass)
                $display("FAIL pass_done: got %b want %b", pass_done, exp_pass);
            else n_pass++;
            n_checks++;
            if (wr_valid !== 1'b1 || addr !== 4'(exp_idx) || bit_out !== rom[exp_idx])
                $display("FAIL gen[%0d]: wr_valid=%b addr=%h bit_out=%h, want 1 %h %h",
                         exp_idx, wr_valid, addr, bit_out, 4'(exp_idx), rom[exp_idx]);
            else n_pass++;
            sb.push_back('{exp_idx, rom[exp_idx]});
            exp_idx = (exp_idx + 1) % 16;
        end
    endtask

    task automatic test_release();
        @(negedge clk);
        reset = 1'b1;
        exp_idx  = 0;
        exp_pass = 1'b0;
        wait_first_write("release");
    endtask

    task automatic test_first_pass();
        run_stream(16);
        n_checks++;
        if (pass_done !== 1'b1) $display("FAIL pass_done_after_pass: got %b want 1", pass_done);
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_stream(6);
    endtask

    task automatic test_mid_reset();
        int guard;
        int nz;
        guard = 0;
        while (exp_idx != 8 && guard < 32) begin
            run_stream(1);
            guard++;
        end
        n_checks++;
        if (addr !== 4'd7) $display("FAIL mid_reset_pos: addr=%h want 7", addr);
        else n_pass++;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if ({addr, bit_out, wr_valid, byte_out, byte_valid, pass_done} !== 23'd0)
            $display("FAIL mid_reset_outputs: addr=%h bit_out=%h wr_valid=%b byte_out=%h byte_valid=%b pass_done=%b, want all 0",
                     addr, bit_out, wr_valid, byte_out, byte_valid, pass_done);
        else n_pass++;
        nz = 0;
        for (int i = 0; i < 16; i++) if (dut.u_ram.mem_q[i] !== 8'h00) nz++;
        n_checks++;
        if (nz != 0) $display("FAIL mid_reset_ram: %0d nonzero words, want 0", nz);
        else n_pass++;
        sb.delete();
        repeat (2) @(negedge clk);
        reset    = 1'b1;
        exp_idx  = 0;
        exp_pass = 1'b0;
        wait_first_write("restart");
        run_stream(17);
    endtask

    task automatic test_ram_peek();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (dut.u_ram.mem_q[i] !== rom[i])
                $display("FAIL ram_peek[%0d]: got %h want %h", i, dut.u_ram.mem_q[i], rom[i]);
            else n_pass++;
        end
    endtask

    initial begin
        string msg;
        msg = "FPGA BitReversal";
        for (int i = 0; i < 16; i++) rom[i] = msg[i];
        n_checks = 0;
        n_pass   = 0;
        exp_idx  = 0;
        exp_pass = 1'b0;
        reset    = 1'b0;

        test_reset();
        test_release();
        test_first_pass();
        test_wrap();
        test_mid_reset();
        test_ram_peek();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
